// File: rtl/wb_openram_pkg.sv
// rtl/wb_openram_pkg.sv - shared OpenRAM wishbone constants, arbiter state encoding and tie-break helper
package wb_openram_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  // With alternation enabled the master that did not win last time takes the tie.
  function automatic arb_state_e arb_tie_winner(input logic rr_en, input logic last_grant);
    if (rr_en && !last_grant) begin
      return GNT1;
    end
    return GNT0;
  endfunction

endpackage

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - two-master wishbone arbiter in front of one RAM port controller
// Optional macro WB_ARB_ROUND_ROBIN_EN: alternate tie winners instead of fixed m0 priority.
module wb_port_arbiter
  import wb_openram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,

  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  input  logic              m0_we_i,
  input  logic [DATA_W/8-1:0] m0_sel_i,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,

  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  input  logic              m1_we_i,
  input  logic [DATA_W/8-1:0] m1_sel_i,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,

  output logic              s_stb_o,
  output logic              s_cyc_o,
  output logic              s_we_o,
  output logic [DATA_W/8-1:0] s_sel_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i
);

`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_e state;
  arb_state_e state_next;
  logic       last_grant;

  logic m0_req;
  logic m1_req;

  assign m0_req = m0_cyc_i && m0_stb_i;
  assign m1_req = m1_cyc_i && m1_stb_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_next;
      if (state == IDLE && state_next == GNT0) begin
        last_grant <= 1'b0;
      end else if (state == IDLE && state_next == GNT1) begin
        last_grant <= 1'b1;
      end
    end
  end

  // Ownership is held on cyc, not stb, so a master's multi-beat cycle is never split.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (m0_req && m1_req) begin
          state_next = arb_tie_winner(RR_EN, last_grant);
        end else if (m0_req) begin
          state_next = GNT0;
        end else if (m1_req) begin
          state_next = GNT1;
        end else begin
          state_next = IDLE;
        end
      end
      GNT0:    state_next = m0_cyc_i ? GNT0 : IDLE;
      GNT1:    state_next = m1_cyc_i ? GNT1 : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_stb_o  = 1'b0;
    s_cyc_o  = 1'b0;
    s_we_o   = 1'b0;
    s_sel_o  = '0;
    s_adr_o  = '0;
    s_dat_o  = '0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    case (state)
      GNT0: begin
        s_stb_o  = m0_stb_i;
        s_cyc_o  = m0_cyc_i;
        s_we_o   = m0_we_i;
        s_sel_o  = m0_sel_i;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        m0_ack_o = s_ack_i;
      end
      GNT1: begin
        s_stb_o  = m1_stb_i;
        s_cyc_o  = m1_cyc_i;
        s_we_o   = m1_we_i;
        s_sel_o  = m1_sel_i;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        m1_ack_o = s_ack_i;
      end
      default: begin
        s_stb_o = 1'b0;
      end
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - directed self-checking bench for wb_port_arbiter
module tb_wb_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

`ifdef WB_ARB_ROUND_ROBIN_EN
  localparam logic RR_BUILD = 1'b1;
`else
  localparam logic RR_BUILD = 1'b0;
`endif

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              m0_stb_i, m0_cyc_i, m0_we_i;
  logic [3:0]        m0_sel_i;
  logic [ADDR_W-1:0] m0_adr_i;
  logic [DATA_W-1:0] m0_dat_i, m0_dat_o;
  logic              m0_ack_o;
  logic              m1_stb_i, m1_cyc_i, m1_we_i;
  logic [3:0]        m1_sel_i;
  logic [ADDR_W-1:0] m1_adr_i;
  logic [DATA_W-1:0] m1_dat_i, m1_dat_o;
  logic              m1_ack_o;
  logic              s_stb_o, s_cyc_o, s_we_o;
  logic [3:0]        s_sel_o;
  logic [ADDR_W-1:0] s_adr_o;
  logic [DATA_W-1:0] s_dat_o, s_dat_i;
  logic              s_ack_i;

  int checks = 0;
  int failures = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic m0_drive(input logic req, input logic we, input logic [3:0] sel,
                          input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat);
    m0_cyc_i = req; m0_stb_i = req; m0_we_i = we; m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
  endtask

  task automatic m1_drive(input logic req, input logic we, input logic [3:0] sel,
                          input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat);
    m1_cyc_i = req; m1_stb_i = req; m1_we_i = we; m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
  endtask

  initial begin
    wb_rst_i = 1'b1;
    s_ack_i  = 1'b0;
    s_dat_i  = '0;
    m0_drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    m1_drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    tick();
    wb_rst_i = 1'b0;

    check("rst_s_cyc", s_cyc_o, 0);
    check("rst_s_adr", s_adr_o, 0);
    check("rst_m0_ack", m0_ack_o, 0);
    check("rst_m1_ack", m1_ack_o, 0);

    // single m0 read
    m0_drive(1'b1, 1'b0, 4'hF, 8'h10, 32'h0);
    #1;
    check("rd_cyc_before_edge", s_cyc_o, 0);
    tick();
    check("rd_s_cyc", s_cyc_o, 1);
    check("rd_s_adr", s_adr_o, 8'h10);
    check("rd_s_we", s_we_o, 0);
    s_ack_i = 1'b1;
    s_dat_i = 32'h1234_5678;
    #1;
    check("rd_m0_ack", m0_ack_o, 1);
    check("rd_m1_ack", m1_ack_o, 0);
    check("rd_m0_dat", m0_dat_o, 32'h1234_5678);
    check("rd_m1_dat", m1_dat_o, 32'h1234_5678);
    tick();
    s_ack_i = 1'b0;
    m0_drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    check("rd_idle_cyc", s_cyc_o, 0);

    // m0 holds through two transfers while m1 waits
    m0_drive(1'b1, 1'b0, 4'hF, 8'h20, 32'h0);
    tick();
    m1_drive(1'b1, 1'b1, 4'h3, 8'h44, 32'hDEAD_BEEF);
    for (int i = 0; i < 2; i++) begin
      s_ack_i = 1'b1;
      #1;
      check("hold_m0_ack", m0_ack_o, 1);
      check("hold_m1_ack", m1_ack_o, 0);
      tick();
      s_ack_i = 1'b0;
      tick();
      check("hold_s_adr", s_adr_o, 8'h20);
    end
    m0_drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    s_ack_i = 1'b1;
    #1;
    check("dead_s_cyc", s_cyc_o, 0);
    check("dead_m1_ack", m1_ack_o, 0);
    s_ack_i = 1'b0;
    tick();

    // now in GNT1 with the m1 write
    check("g1_s_cyc", s_cyc_o, 1);
    check("g1_s_adr", s_adr_o, 8'h44);
    check("g1_s_we", s_we_o, 1);
    check("g1_s_sel", s_sel_o, 4'b0011);
    check("g1_s_dat", s_dat_o, 32'hDEAD_BEEF);
    s_ack_i = 1'b1;
    #1;
    check("g1_m1_ack", m1_ack_o, 1);
    check("g1_m0_ack", m0_ack_o, 0);

    // reset mid-transfer with m1 cyc still high
    wb_rst_i = 1'b1;
    tick();
    check("rstmid_s_cyc", s_cyc_o, 0);
    check("rstmid_s_stb", s_stb_o, 0);
    check("rstmid_s_we", s_we_o, 0);
    check("rstmid_s_dat", s_dat_o, 0);
    check("rstmid_s_sel", s_sel_o, 0);
    check("rstmid_m0_ack", m0_ack_o, 0);
    check("rstmid_m1_ack", m1_ack_o, 0);
    wb_rst_i = 1'b0;
    s_ack_i  = 1'b0;
    m1_drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();

    // ties: first always m0, second depends on build
    m0_drive(1'b1, 1'b0, 4'hF, 8'hA0, 32'h0);
    m1_drive(1'b1, 1'b0, 4'hF, 8'hB1, 32'h0);
    tick();
    check("tie1_s_adr", s_adr_o, 8'hA0);
    m0_drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    m1_drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    check("tie1_idle", s_cyc_o, 0);
    m0_drive(1'b1, 1'b0, 4'hF, 8'hA0, 32'h0);
    m1_drive(1'b1, 1'b0, 4'hF, 8'hB1, 32'h0);
    tick();
    check("tie2_s_adr", s_adr_o, RR_BUILD ? 8'hB1 : 8'hA0);
    m0_drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    m1_drive(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();

    // quiet bus
    for (int i = 0; i < 10; i++) begin
      tick();
      check("quiet_s_cyc", s_cyc_o, 0);
      check("quiet_state", dut.state, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, meaning width of the word address forwarded to the RAM port.
REQ-002 SHALL have parameter DATA_W, default 32, meaning width of the data bus.
REQ-003 SHALL have port wb_clk_i  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port wb_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have, for N in {0,1}, ports mN_stb_i, mN_cyc_i, mN_we_i  input  1 each  Wishbone master N strobe, cycle and write-enable.
REQ-006 SHALL have, for N in {0,1}, port mN_sel_i  input  DATA_W/8  byte select.
REQ-007 SHALL have, for N in {0,1}, port mN_adr_i  input  ADDR_W  word address.
REQ-008 SHALL have, for N in {0,1}, port mN_dat_i  input  DATA_W  write data.
REQ-009 SHALL have, for N in {0,1}, ports mN_dat_o  output  DATA_W  read data, and mN_ack_o  output  1  acknowledge.
REQ-010 SHALL have ports s_stb_o, s_cyc_o, s_we_o  output  1 each  to the downstream RAM port controller.
REQ-011 SHALL have ports s_sel_o  output  DATA_W/8, s_adr_o  output  ADDR_W, s_dat_o  output  DATA_W  to the downstream controller.
REQ-012 SHALL have ports s_dat_i  input  DATA_W  and s_ack_i  input  1  from the downstream controller.

Function
REQ-013 SHALL define mN request as mN_cyc_i && mN_stb_i.
REQ-014 SHALL implement FSM states IDLE, GNT0 and GNT1, with grant registered: a request seen in IDLE takes effect on the s_* outputs one clock later.
REQ-015 In IDLE, SHALL go to GNT0 if only m0 requests, to GNT1 if only m1 requests, and stay in IDLE if neither requests.
REQ-016 In IDLE with both masters requesting, SHALL select the winner per REQ-026/REQ-027.
REQ-017 In GNTn, SHALL stay while mn_cyc_i is 1 and SHALL go to IDLE on the first edge where mn_cyc_i is 0, giving one dead cycle between owners and no direct GNT0<->GNT1 transition.
REQ-018 In GNTn, SHALL drive s_stb_o, s_cyc_o, s_we_o, s_sel_o, s_adr_o and s_dat_o combinationally from master n.
REQ-019 In IDLE, SHALL drive all s_* outputs to 0.
REQ-020 In GNTn, SHALL drive mn_ack_o = s_ack_i combinationally; the non-granted master's ack SHALL be 0, and both acks SHALL be 0 in IDLE.
REQ-021 SHALL drive m0_dat_o = m1_dat_o = s_dat_i unconditionally.
REQ-022 SHALL never change grant while the granted mn_cyc_i is high; a competing request SHALL wait with ack 0, never be dropped.
REQ-023 SHALL update the last_grant register to n on every IDLE->GNTn transition.

Reset
REQ-024 While wb_rst_i is 1 at a rising edge, SHALL set state IDLE and last_grant=1, so m0 wins the first tie; with REQ-019/REQ-020 this makes every s_* output and both acks 0 after that edge.
REQ-025 Reset asserted mid-transaction SHALL abort the grant at the next edge, s_cyc_o returning to 0 regardless of master cyc.

Configuration
REQ-026 With macro WB_ARB_ROUND_ROBIN_EN defined, a tie in IDLE SHALL grant the master not equal to last_grant.
REQ-027 Without WB_ARB_ROUND_ROBIN_EN, a tie SHALL always grant m0 and last_grant SHALL be kept but unused.

Structure
REQ-028 SHALL take FSM state encodings (IDLE=2'd0, GNT0=2'd1, GNT1=2'd2) from the shared package wb_openram_pkg, alongside the RAM default ADDR_W/DATA_W constants.
REQ-029 SHALL be a single module with no sub-module; output muxing is inline and selected by state.

Verification
REQ-030 Reset, then m0 requests read at adr 0x10 -> s_cyc_o=1 one cycle later, s_adr_o=0x10, s_ack_i pulse appears on m0_ack_o only, m1_ack_o=0.
REQ-031 m0 holds cyc through two transfers while m1 requests -> m1 receives no ack until m0_cyc_i drops, then IDLE one cycle, then GNT1.
REQ-032 Tie after reset, round-robin build -> m0 granted first; next tie -> m1 granted; fixed-priority build -> m0 both times.
REQ-033 m1 write, sel=4'b0011, dat=0xDEADBEEF -> s_we_o=1, s_sel_o=4'b0011, s_dat_o=0xDEADBEEF while in GNT1.
REQ-034 wb_rst_i asserted in GNT1 mid-transfer -> next edge state IDLE, all s_* outputs 0, both acks 0.
REQ-035 No requests for 10 cycles -> s_cyc_o stays 0, state stays IDLE.
